des_sbox_seq: RTL and testbench

Time-multiplexed DES S-box substitution unit. It maps a 48-bit expanded, key-mixed half-block to the 32-bit S-layer output. All eight standard DES S-boxes (S1..S8) are held in internal ROM, and a parameter sets how many lookups run per cycle. The block sits in the DES round datapath between the E-expansion/key-XOR stage and the P-permutation. Valid/ready handshakes on both sides let the round controller stall it.

---
 rtl/des_sbox_seq_if.sv | 14 +
 rtl/des_sbox_seq.sv | 129 ++++++++++++
 tb/tb_des_sbox_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_seq_if.sv
// Valid/ready bus between the round controller and the S-box unit.
interface des_sbox_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
endinterface

// File: rtl/des_sbox_seq.sv
// Time-multiplexed DES S-layer: LANES S-box lookups per cycle over 8/LANES
// LOOKUP cycles, result held in DONE until the consumer takes it.

// One lookup lane: box number selects which of S1..S8 is read this cycle.
module des_sbox_lane (
    input  logic [2:0] box,
    input  logic [5:0] din,
    output logic [3:0] dout
);
    logic [255:0] tbl;
    logic [5:0]   idx;

    // Each box is four 16-nibble rows, row 0 in the top 64 bits.
    always_comb begin
        tbl = '0;
        case (box)
            3'd0: tbl = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                         64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
            3'd1: tbl = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                         64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
            3'd2: tbl = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                         64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
            3'd3: tbl = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                         64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
            3'd4: tbl = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                         64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
            3'd5: tbl = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                         64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
            3'd6: tbl = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                         64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
            3'd7: tbl = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                         64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
            default: tbl = '0;
        endcase
    end

    // Entry number row*16+col counts nibbles from the MSB, so the bit
    // offset from the LSB is (63-idx)*4.
    assign idx  = {din[5], din[0], din[4:1]};
    assign dout = tbl[{~idx, 2'b00} +: 4];
endmodule

module des_sbox_seq #(
    parameter int LANES = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    des_sbox_seq_if.slave bus,
    output logic          busy
);
    localparam int         STEPS = 8 / LANES;
    localparam logic [2:0] LAST  = 3'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

    state_t                     state, state_n;
    logic [2:0]                 step;
    logic [47:0]                work;
    logic [31:0]                result;
    logic                       ov_q;
    logic [LANES-1:0][2:0]      box_idx;
    logic [LANES-1:0][47:0]     shl;
    logic [LANES-1:0][5:0]      lane_in;
    logic [LANES-1:0][3:0]      lane_out;

    // Lane g handles box step*LANES+g; the shift brings its 6 bits to the top.
    for (genvar g = 0; g < LANES; g++) begin : g_lane_sel
        assign box_idx[g] = 3'(int'(step) * LANES + g);
        assign shl[g]     = work << (6 * int'(box_idx[g]));
        assign lane_in[g] = shl[g][47:42];
    end

    des_sbox_lane u_lane [LANES-1:0] (
        .box  (box_idx),
        .din  (lane_in),
        .dout (lane_out)
    );

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid)     state_n = LOOKUP;
            LOOKUP:  if (step == LAST)     state_n = DONE;
            DONE:    if (bus.out_ready)    state_n = IDLE;
            default:                       state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Work/result/step datapath; out_valid is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            result <= '0;
            step   <= '0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= (state_n == DONE);
            case (state)
                IDLE: if (bus.in_valid) begin
                    work   <= bus.in_data;
                    result <= '0;
                    step   <= '0;
                end
                LOOKUP: begin
                    for (int i = 0; i < LANES; i++)
                        result[28 - 4 * int'(box_idx[i]) +: 4] <= lane_out[i];
                    if (step != LAST) step <= step + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.out_data  = result;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_des_sbox_seq.sv
// Bench for des_sbox_seq: one DUT per legal LANES value (index k -> LANES=1<<k),
// directed steps with a scoreboard queue of expected S-layer outputs.
module tb_des_sbox_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  iv   = '0;
    logic [3:0]  ordy = '0;
    logic [47:0] idat [4];
    wire  [3:0]  ir, ov, bsy;
    wire  [31:0] odat [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_seq_if bus();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idat[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]   = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign odat[g] = bus.out_data;
        des_sbox_seq #(.LANES(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave),
            .busy  (bsy[g])
        );
    end

    // FIPS 46-3 tables, four rows per box, each row 16 nibbles MSB-first.
    logic [63:0] tbl [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    int checks = 0;
    int failures = 0;
    logic [31:0] sbq [$];

    function automatic logic [3:0] sb(input int box, input logic [5:0] b);
        int row, col;
        logic [63:0] rv;
        row = int'({b[5], b[0]});
        col = int'(b[4:1]);
        rv  = tbl[box * 4 + row];
        return rv[60 - 4 * col +: 4];
    endfunction

    function automatic logic [31:0] model(input logic [47:0] d);
        logic [31:0] r;
        r = '0;
        for (int bx = 0; bx < 8; bx++)
            r[28 - 4 * bx +: 4] = sb(bx, d[42 - 6 * bx +: 6]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present d to DUT k, wait (bounded) for in_ready; returns #1 after the accepting edge.
    task automatic send(input int k, input logic [47:0] d);
        int n;
        n = 0;
        while (!ir[k] && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", 64'(ir[k]), 64'd1);
        idat[k] = d;
        iv[k]   = 1'b1;
        @(posedge clk); #1;
        iv[k]   = 1'b0;
        sbq.push_back(model(d));
    endtask

    // One full transaction: latency, data, and the DONE->IDLE handshake.
    task automatic run_txn(input int k, input logic [47:0] d, input string tag,
                           output logic [31:0] obs);
        int lat;
        logic [31:0] exp;
        send(k, d);
        lat = 0;
        while (!ov[k] && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(8 >> k));
        exp = (sbq.size() > 0) ? sbq.pop_front() : 32'hxxxxxxxx;
        obs = odat[k];
        chk({tag, "_data"}, 64'(obs), 64'(exp));
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk({tag, "_ov_fall"}, 64'(ov[k]), 64'd0);
        chk({tag, "_ir_rise"}, 64'(ir[k]), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [47:0] vec [10];
        int bc, lat, got, last, vi;
        logic acc, st_ov, st_od, st_ir;

        for (int k = 0; k < 4; k++) idat[k] = '0;

        // Reset values on all four DUTs.
        #12;
        chk("rst_in_ready", 64'(ir), 64'hF);
        chk("rst_out_valid", 64'(ov), 64'h0);
        chk("rst_busy", 64'(bsy), 64'h0);
        chk("rst_out_data", 64'({odat[0], odat[1]} | {odat[2], odat[3]}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero vector, LANES=8.
        run_txn(3, 48'h0, "zero_l8", obs);
        chk("zero_l8_const", 64'(obs), 64'hEFA72C4D);

        // All ones, LANES=1, out_ready held high: latency 8, busy for 9 cycles.
        ordy[0] = 1'b1;
        send(0, 48'hFFFF_FFFF_FFFF);
        bc = 0; lat = -1; obs = '0;
        for (int c = 0; c < 20; c++) begin
            if (bsy[0]) bc++;
            if (ov[0] && lat < 0) begin lat = c; obs = odat[0]; end
            @(posedge clk); #1;
        end
        ordy[0] = 1'b0;
        chk("ones_l1_lat", 64'(lat), 64'd8);
        chk("ones_l1_busy", 64'(bc), 64'd9);
        chk("ones_l1_data", 64'(obs), 64'(sbq.pop_front()));
        chk("ones_l1_const", 64'(obs), 64'hD9CE3DCB);

        // S3 slot sweep on every LANES value.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 64; j++) begin
                run_txn(k, 48'(j) << 30, "s3_sweep", obs);
                chk("s3_other_nibbles", 64'(obs & 32'hFF0FFFFF), 64'hEF072C4D);
                if (j == 0)  chk("s3_min", 64'(obs[23:20]), 64'd10);
                if (j == 63) chk("s3_max", 64'(obs[23:20]), 64'd12);
            end
        end

        // Backpressure on LANES=4: 20 stalled cycles with in_data churning.
        send(2, 48'h1234_5678_9ABC);
        lat = 0;
        while (!ov[2] && lat < 40) begin @(posedge clk); #1; lat++; end
        obs = odat[2];
        chk("bp_data", 64'(obs), 64'(sbq.pop_front()));
        st_ov = 1'b1; st_od = 1'b1; st_ir = 1'b1;
        for (int c = 0; c < 20; c++) begin
            idat[2] = {16'($urandom), 32'($urandom)};
            iv[2]   = 1'b1;
            @(posedge clk); #1;
            if (ov[2] !== 1'b1) st_ov = 1'b0;
            if (odat[2] !== obs) st_od = 1'b0;
            if (ir[2] !== 1'b0) st_ir = 1'b0;
        end
        iv[2] = 1'b0;
        chk("bp_ov_held", 64'(st_ov), 64'd1);
        chk("bp_data_held", 64'(st_od), 64'd1);
        chk("bp_ir_low", 64'(st_ir), 64'd1);
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        ordy[2] = 1'b0;
        chk("bp_release_ov", 64'(ov[2]), 64'd0);
        chk("bp_release_ir", 64'(ir[2]), 64'd1);
        @(posedge clk); #1;
        chk("bp_no_second", 64'({ov[2], bsy[2]}), 64'd0);

        // Reset mid-LOOKUP on LANES=1 at step 3.
        send(0, 48'h0);
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy_pre", 64'(bsy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ir", 64'(ir[0]), 64'd1);
        chk("mid_rst_ov", 64'(ov[0]), 64'd0);
        chk("mid_rst_busy", 64'(bsy[0]), 64'd0);
        chk("mid_rst_data", 64'(odat[0]), 64'd0);
        sbq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bc = 0;
        for (int c = 0; c < 10; c++) begin
            if (ov[0]) bc++;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_pulse", 64'(bc), 64'd0);
        run_txn(0, 48'h0, "post_rst", obs);
        chk("post_rst_const", 64'(obs), 64'hEFA72C4D);

        // Back-to-back on LANES=2: IDLE + 4 LOOKUP + DONE = 6 cycles per result.
        for (int i = 0; i < 10; i++) vec[i] = {16'($urandom), 32'($urandom)};
        ordy[1] = 1'b1; iv[1] = 1'b1; idat[1] = vec[0];
        vi = 0; got = 0; last = -1;
        for (int c = 0; c < 300 && got < 10; c++) begin
            acc = ir[1] && iv[1];
            if (acc) sbq.push_back(model(idat[1]));
            if (ov[1]) begin
                chk("b2b_data", 64'(odat[1]), 64'((sbq.size() > 0) ? sbq.pop_front() : 32'hxxxxxxxx));
                if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd6);
                last = c;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                vi++;
                if (vi < 10) idat[1] = vec[vi];
                else         iv[1] = 1'b0;
            end
        end
        iv[1] = 1'b0; ordy[1] = 1'b0;
        chk("b2b_count", 64'(got), 64'd10);
        chk("b2b_sb_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
